// File: rtl/mul_pipe_mode.sv
`default_nettype none
// mul_pipe_mode: pipelined multiplier with per-transaction signedness mode,
// optional output saturation and a valid/ready handshake with bubble collapse.
module mul_pipe_mode #(
   parameter int din0_WIDTH = 8,
   parameter int din1_WIDTH = 4,
   parameter int dout_WIDTH = 12,
   parameter int NUM_STAGE  = 3,
   parameter int SATURATE   = 0
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic [1:0]            mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  ovf
);
   // One extra bit lets every mode share a single signed multiplier exactly.
   localparam int C_PW = din0_WIDTH + din1_WIDTH + 1;

   logic                   a_signed_d;
   logic                   b_signed_d;
   logic signed [C_PW-1:0] a_ext_d;
   logic signed [C_PW-1:0] b_ext_d;
   logic signed [C_PW-1:0] prod_d;
   logic                   ovf_d;
   logic [dout_WIDTH-1:0]  res_d;

   always_comb begin
      a_signed_d = (mode != 2'b01);
      b_signed_d = (mode[1] == mode[0]);
      a_ext_d    = {{(C_PW-din0_WIDTH){a_signed_d & din0[din0_WIDTH-1]}}, din0};
      b_ext_d    = {{(C_PW-din1_WIDTH){b_signed_d & din1[din1_WIDTH-1]}}, din1};
      prod_d     = a_ext_d * b_ext_d;

      // Signed results fit when all bits above the target sign bit agree.
      if (a_signed_d) begin
         ovf_d = !((&prod_d[C_PW-1:dout_WIDTH-1]) || !(|prod_d[C_PW-1:dout_WIDTH-1]));
      end else begin
         ovf_d = |prod_d[C_PW-1:dout_WIDTH];
      end

      res_d = prod_d[dout_WIDTH-1:0];
      if ((SATURATE != 0) && ovf_d) begin
         if (!a_signed_d) begin
            res_d = '1;
         end else if (prod_d[C_PW-1]) begin
            res_d = {1'b1, {(dout_WIDTH-1){1'b0}}};
         end else begin
            res_d = {1'b0, {(dout_WIDTH-1){1'b1}}};
         end
      end
   end

   logic [NUM_STAGE-1:0]  vld;
   logic [NUM_STAGE-1:0]  ovfs;
   logic [dout_WIDTH-1:0] dat [NUM_STAGE];
   logic [NUM_STAGE-1:0]  rdy;

   for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
      logic                  up_vld;
      logic                  up_ovf;
      logic [dout_WIDTH-1:0] up_dat;
      logic                  v_q;
      logic                  o_q;
      logic [dout_WIDTH-1:0] d_q;

      if (k == 0) begin : g_head
         assign up_vld = in_valid;
         assign up_ovf = ovf_d;
         assign up_dat = res_d;
      end else begin : g_body
         assign up_vld = vld[k-1];
         assign up_ovf = ovfs[k-1];
         assign up_dat = dat[k-1];
      end

      // A stage can load unless it and every stage after it are full and the
      // consumer is stalled; this lets bubbles collapse without a ready chain.
      assign rdy[k] = out_ready || !(&vld[NUM_STAGE-1:k]);

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
         if (!ap_rst_n) begin
            v_q <= 1'b0;
            o_q <= 1'b0;
            d_q <= '0;
         end else if (rdy[k]) begin
            v_q <= up_vld;
            if (up_vld) begin
               o_q <= up_ovf;
               d_q <= up_dat;
            end
         end
      end

      assign vld[k]  = v_q;
      assign ovfs[k] = o_q;
      assign dat[k]  = d_q;
   end

   assign in_ready  = rdy[0];
   assign out_valid = vld[NUM_STAGE-1];
   assign ovf       = ovfs[NUM_STAGE-1];
   assign dout      = dat[NUM_STAGE-1];

endmodule
`default_nettype wire
